// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer
// Writeback buffer that owns the register-file write port. Writeback requests
// are queued in a DEPTH-entry FIFO and drained one per cycle onto a registered
// write port (rd_addr/rd_w_data). Writes to r0 are dropped at the input. While
// a write is pending (queued or currently presented on the write port), reads
// of that register are forwarded from the youngest pending value.
//
// Ports
//   clk          system clock, rising-edge active
//   rst          asynchronous active-low reset
//   in_valid     writeback request present
//   in_ready     buffer has room (count < DEPTH)
//   in_addr      destination register index
//   in_data      destination register value
//   stall        register-file write port busy; hold the drain
//   rd_addr      registered write address (0 = no write)
//   rd_w_data    registered write data
//   rs_addr      read-port A address snooped for forwarding
//   rt_addr      read-port B address snooped for forwarding
//   rs_fwd_hit   pending write matches rs_addr
//   rs_fwd_data  forwarded value for rs_addr
//   rt_fwd_hit   pending write matches rt_addr
//   rt_fwd_data  forwarded value for rt_addr
//   count        occupied FIFO entries
module regfile_wb_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [4:0]               in_addr,
   input  logic [31:0]              in_data,
   input  logic                     stall,
   output logic [4:0]               rd_addr,
   output logic [31:0]              rd_w_data,
   input  logic [4:0]               rs_addr,
   input  logic [4:0]               rt_addr,
   output logic                     rs_fwd_hit,
   output logic [31:0]              rs_fwd_data,
   output logic                     rt_fwd_hit,
   output logic [31:0]              rt_fwd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [4:0]    mem_addr_r [DEPTH];
   logic [31:0]   mem_data_r [DEPTH];
   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic [4:0]    rd_addr_r;
   logic [31:0]   rd_w_data_r;

   logic          accept_s;
   logic          push_s;
   logic          pop_s;
   logic          rs_hit_s;
   logic [31:0]   rs_data_s;
   logic          rt_hit_s;
   logic [31:0]   rt_data_s;
   logic [PW-1:0] idx_s;
   logic          live_s;
   logic          rs_match_s;
   logic          rt_match_s;

   assign in_ready = (count_r < DEPTH_C);
   assign accept_s = in_valid & in_ready;
   // r0 requests complete the handshake but never enter the FIFO
   assign push_s   = accept_s & (in_addr != 5'd0);
   assign pop_s    = (count_r != {CW{1'b0}}) & ~stall;

   // FIFO storage, pointers, occupancy and the registered write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_addr_r[i] <= 5'd0;
            mem_data_r[i] <= 32'd0;
         end
         head_r      <= {PW{1'b0}};
         tail_r      <= {PW{1'b0}};
         count_r     <= {CW{1'b0}};
         rd_addr_r   <= 5'd0;
         rd_w_data_r <= 32'd0;
      end else begin
         if (push_s) begin
            mem_addr_r[tail_r] <= in_addr;
            mem_data_r[tail_r] <= in_data;
            tail_r             <= tail_r + PTR_ONE;
         end else begin
            tail_r <= tail_r;
         end

         // An idle or stalled cycle drives a write to r0, which is a no-op
         if (pop_s) begin
            rd_addr_r   <= mem_addr_r[head_r];
            rd_w_data_r <= mem_data_r[head_r];
            head_r      <= head_r + PTR_ONE;
         end else begin
            rd_addr_r   <= 5'd0;
            rd_w_data_r <= 32'd0;
         end

         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Forwarding: the write port holds the oldest pending value; FIFO entries
   // are scanned oldest to youngest so the youngest match overrides.
   always_comb begin
      idx_s      = {PW{1'b0}};
      live_s     = 1'b0;
      rs_match_s = 1'b0;
      rt_match_s = 1'b0;
      rs_hit_s   = (rs_addr != 5'd0) && (rs_addr == rd_addr_r);
      rs_data_s  = rs_hit_s ? rd_w_data_r : 32'd0;
      rt_hit_s   = (rt_addr != 5'd0) && (rt_addr == rd_addr_r);
      rt_data_s  = rt_hit_s ? rd_w_data_r : 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         idx_s      = head_r + PW'(i);
         live_s     = (CW'(i) < count_r);
         rs_match_s = live_s && (rs_addr != 5'd0) && (mem_addr_r[idx_s] == rs_addr);
         rt_match_s = live_s && (rt_addr != 5'd0) && (mem_addr_r[idx_s] == rt_addr);
         rs_hit_s   = rs_hit_s | rs_match_s;
         rs_data_s  = rs_match_s ? mem_data_r[idx_s] : rs_data_s;
         rt_hit_s   = rt_hit_s | rt_match_s;
         rt_data_s  = rt_match_s ? mem_data_r[idx_s] : rt_data_s;
      end
   end

   assign rd_addr     = rd_addr_r;
   assign rd_w_data   = rd_w_data_r;
   assign count       = count_r;
   assign rs_fwd_hit  = rs_hit_s;
   assign rs_fwd_data = rs_data_s;
   assign rt_fwd_hit  = rt_hit_s;
   assign rt_fwd_data = rt_data_s;

endmodule
